// File: rtl/decode_queue_pkg.sv
// Opcode/funct constants and the packed micro-op carried from decode to issue.
package decode_queue_pkg;

  localparam int UOP_DATA_W  = 32;
  localparam int UOP_RADDR_W = 5;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_ALUI_LO  = 6'h08;
  localparam logic [5:0] OP_ALUI_HI  = 6'h0F;
  localparam logic [5:0] OP_LOAD_LO  = 6'h20;
  localparam logic [5:0] OP_LOAD_HI  = 6'h25;
  localparam logic [5:0] OP_STORE_LO = 6'h28;
  localparam logic [5:0] OP_STORE_HI = 6'h2B;
  localparam logic [5:0] FN_JR       = 6'h08;

  localparam logic [UOP_RADDR_W-1:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic [UOP_RADDR_W-1:0] addra;
    logic [UOP_RADDR_W-1:0] addrb;
    logic [UOP_RADDR_W-1:0] regdest;
    logic [4:0]             shiftamt;
    logic [UOP_DATA_W-1:0]  imedext;
    logic [UOP_DATA_W-1:0]  nextpc;
    logic                   writereg;
    logic                   readmem;
    logic                   writemem;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

endpackage

// File: rtl/decode_queue_if.sv
// Fetch->decode and decode->issue handshake bundle; slave is the queue side.
interface decode_queue_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 3
) ();
  logic               if_id_valid;
  logic               if_id_ready;
  logic [DATA_W-1:0]  if_id_instruc;
  logic [DATA_W-1:0]  if_id_nextpc;
  logic               id_is_valid;
  logic               is_id_ready;
  logic [RADDR_W-1:0] id_is_addra;
  logic [RADDR_W-1:0] id_is_addrb;
  logic [RADDR_W-1:0] id_is_regdest;
  logic [4:0]         id_is_shiftamt;
  logic [DATA_W-1:0]  id_is_imedext;
  logic [DATA_W-1:0]  id_is_nextpc;
  logic               id_is_writereg;
  logic               id_is_readmem;
  logic               id_is_writemem;
  logic [CNT_W-1:0]   id_if_count;

  modport slave (
    input  if_id_valid, if_id_instruc, if_id_nextpc, is_id_ready,
    output if_id_ready, id_is_valid, id_is_addra, id_is_addrb, id_is_regdest,
           id_is_shiftamt, id_is_imedext, id_is_nextpc, id_is_writereg,
           id_is_readmem, id_is_writemem, id_if_count
  );

  modport master (
    output if_id_valid, if_id_instruc, if_id_nextpc, is_id_ready,
    input  if_id_ready, id_is_valid, id_is_addra, id_is_addrb, id_is_regdest,
           id_is_shiftamt, id_is_imedext, id_is_nextpc, id_is_writereg,
           id_is_readmem, id_is_writemem, id_if_count
  );
endinterface

// File: rtl/decode_queue_fields.sv
// Combinational instruction decode into a micro-op; zero latency, no flow control.
module decode_queue_fields
  import decode_queue_pkg::*;
(
  input  logic [UOP_DATA_W-1:0] i_instr,
  input  logic [UOP_DATA_W-1:0] i_nextpc,
  output uop_t                  o_uop
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_is_alui;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_zext;

  assign w_op       = i_instr[31:26];
  assign w_fn       = i_instr[5:0];
  assign w_is_alui  = (w_op >= OP_ALUI_LO) && (w_op <= OP_ALUI_HI);
  assign w_is_load  = (w_op >= OP_LOAD_LO) && (w_op <= OP_LOAD_HI);
  assign w_is_store = (w_op >= OP_STORE_LO) && (w_op <= OP_STORE_HI);
  // Logical immediates are unsigned; everything else sign-extends.
  assign w_zext     = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);

  always_comb begin
    o_uop          = '0;
    o_uop.addra    = i_instr[25:21];
    o_uop.addrb    = i_instr[20:16];
    o_uop.shiftamt = i_instr[10:6];
    o_uop.nextpc   = i_nextpc;
    o_uop.imedext  = w_zext ? {16'h0000, i_instr[15:0]} : {{16{i_instr[15]}}, i_instr[15:0]};
    if (w_op == OP_RTYPE)    o_uop.regdest = i_instr[15:11];
    else if (w_op == OP_JAL) o_uop.regdest = REG_LINK;
    else                     o_uop.regdest = i_instr[20:16];
    o_uop.writereg = ((w_op == OP_RTYPE) && (w_fn != FN_JR)) || w_is_alui || w_is_load ||
                     (w_op == OP_JAL);
    o_uop.readmem  = w_is_load;
    o_uop.writemem = w_is_store;
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetched instructions into a DEPTH-entry micro-op FIFO, one-cycle latency
// (no fall-through); fetch stalls via if_id_ready when full, issue drains via is_id_ready.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int DROP_NOP = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  decode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  uop_t              r_mem [DEPTH];

  logic [DATA_W-1:0] w_instr;
  uop_t              w_uop;
  uop_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_nop;
  logic              w_store;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_instr = bus.if_id_instruc;
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.if_id_valid & ~w_full;
  // A dropped NOP still completes the fetch handshake; it just never occupies a slot.
  assign w_nop   = (DROP_NOP != 0) && (w_instr == '0);
  assign w_store = w_push & ~w_nop;
  assign w_pop   = ~w_empty & bus.is_id_ready;

  decode_queue_fields u_fields (
    .i_instr  (w_instr),
    .i_nextpc (bus.if_id_nextpc),
    .o_uop    (w_uop)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) r_mem[r_wr_ptr] <= w_uop;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign bus.if_id_ready    = ~w_full;
  assign bus.id_is_valid    = ~w_empty;
  assign bus.id_is_addra    = RADDR_W'(w_head.addra);
  assign bus.id_is_addrb    = RADDR_W'(w_head.addrb);
  assign bus.id_is_regdest  = RADDR_W'(w_head.regdest);
  assign bus.id_is_shiftamt = w_head.shiftamt;
  assign bus.id_is_imedext  = DATA_W'(w_head.imedext);
  assign bus.id_is_nextpc   = DATA_W'(w_head.nextpc);
  assign bus.id_is_writereg = w_head.writereg;
  assign bus.id_is_readmem  = w_head.readmem;
  assign bus.id_is_writemem = w_head.writemem;
  assign bus.id_if_count    = r_count;

endmodule
